// File: rtl/coin_change_dispenser_if.sv
// Controller-to-dispenser bundle: change counts in, hopper drives and payout status out.
// The controller (or bench) takes the master modport, the dispenser the slave modport.
interface coin_change_dispenser_if #(
   parameter int CW = 4
);
   logic          load;
   logic [CW-1:0] cnt1;
   logic [CW-1:0] cnt2;
   logic [CW-1:0] cnt5;
   logic          sense;
   logic          drop1;
   logic          drop2;
   logic          drop5;
   logic          busy;
   logic          done;
   logic          fault;
   logic [CW-1:0] rem1;
   logic [CW-1:0] rem2;
   logic [CW-1:0] rem5;
   logic [2:0]    state;

   modport master (
      output load, cnt1, cnt2, cnt5, sense,
      input  drop1, drop2, drop5, busy, done, fault, rem1, rem2, rem5, state
   );

   modport slave (
      input  load, cnt1, cnt2, cnt5, sense,
      output drop1, drop2, drop5, busy, done, fault, rem1, rem2, rem5, state
   );
endinterface

// File: rtl/coin_change_dispenser.sv
// Pays out latched 1/2/5-unit change one coin at a time, pulsing a hopper and awaiting the drop sensor.
// Optional feature macro DISPENSE_RETRY_EN: one re-pulse of the same hopper after the first sensor timeout.
module coin_change_dispenser #(
   parameter int CW          = 4,
   parameter int PULSE_LEN   = 4,
   parameter int ACK_TIMEOUT = 16
) (
   input logic                   clk,
   input logic                   rst,
   coin_change_dispenser_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEL   = 3'd1,
      ST_PULSE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4,
      ST_FAULT = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      DEN_NONE,
      DEN_1,
      DEN_2,
      DEN_5
   } den_e;

   localparam int PW = $clog2(PULSE_LEN + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_LEN - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

`ifdef DISPENSE_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   state_e        state_q;
   den_e          den_q;
   logic [CW-1:0] rem1_q, rem2_q, rem5_q;
   logic [PW-1:0] pulse_cnt_q;
   logic [TW-1:0] wait_cnt_q;
   logic          coin_seen_q;
   logic          retry_q;
   logic          drop1_q, drop2_q, drop5_q;
   logic          busy_q, done_q, fault_q;

   den_e          sel_den_d;
   logic [CW-1:0] rem1_d, rem2_d, rem5_d;
   logic          last_coin_d;
   logic          cnt_zero_d;

   // Remaining counts as they would stand once the in-flight coin is credited.
   always_comb begin
      sel_den_d = DEN_NONE;
      if (rem5_q != '0)      sel_den_d = DEN_5;
      else if (rem2_q != '0) sel_den_d = DEN_2;
      else if (rem1_q != '0) sel_den_d = DEN_1;

      rem1_d = rem1_q;
      rem2_d = rem2_q;
      rem5_d = rem5_q;
      case (den_q)
         DEN_1:   if (rem1_q != '0) rem1_d = rem1_q - CW'(1);
         DEN_2:   if (rem2_q != '0) rem2_d = rem2_q - CW'(1);
         DEN_5:   if (rem5_q != '0) rem5_d = rem5_q - CW'(1);
         default: ;
      endcase

      last_coin_d = (rem1_d == '0) && (rem2_d == '0) && (rem5_d == '0);
      cnt_zero_d  = (bus.cnt1 == '0) && (bus.cnt2 == '0) && (bus.cnt5 == '0);
   end

   // NOTE: reset is synchronous and reaches every register, so an abort mid-payout drops the solenoid at that same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         den_q       <= DEN_NONE;
         rem1_q      <= '0;
         rem2_q      <= '0;
         rem5_q      <= '0;
         pulse_cnt_q <= '0;
         wait_cnt_q  <= '0;
         coin_seen_q <= 1'b0;
         retry_q     <= 1'b0;
         drop1_q     <= 1'b0;
         drop2_q     <= 1'b0;
         drop5_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
               if (bus.load) begin
                  rem1_q  <= bus.cnt1;
                  rem2_q  <= bus.cnt2;
                  rem5_q  <= bus.cnt5;
                  retry_q <= 1'b0;
                  fault_q <= 1'b0;
                  if (cnt_zero_d) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_SEL;
                     busy_q  <= 1'b1;
                  end
               end else if (state_q == ST_DONE) begin
                  state_q <= ST_IDLE;
               end
            end

            ST_SEL: begin
               den_q       <= sel_den_d;
               pulse_cnt_q <= '0;
               coin_seen_q <= 1'b0;
               if (sel_den_d == DEN_NONE) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= ST_PULSE;
                  drop1_q <= (sel_den_d == DEN_1);
                  drop2_q <= (sel_den_d == DEN_2);
                  drop5_q <= (sel_den_d == DEN_5);
               end
            end

            ST_PULSE: begin
               if (bus.sense) coin_seen_q <= 1'b1;
               if (pulse_cnt_q == PULSE_LAST) begin
                  drop1_q <= 1'b0;
                  drop2_q <= 1'b0;
                  drop5_q <= 1'b0;
                  // A sensor edge on the final pulse cycle still counts for this coin.
                  if (coin_seen_q || bus.sense) begin
                     rem1_q  <= rem1_d;
                     rem2_q  <= rem2_d;
                     rem5_q  <= rem5_d;
                     retry_q <= 1'b0;
                     if (last_coin_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q <= ST_SEL;
                     end
                  end else begin
                     state_q    <= ST_WAIT;
                     wait_cnt_q <= '0;
                  end
               end else begin
                  pulse_cnt_q <= pulse_cnt_q + PW'(1);
               end
            end

            ST_WAIT: begin
               if (bus.sense) begin
                  rem1_q  <= rem1_d;
                  rem2_q  <= rem2_d;
                  rem5_q  <= rem5_d;
                  retry_q <= 1'b0;
                  if (last_coin_d) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_SEL;
                  end
               end else if (wait_cnt_q == TIMEOUT_LAST) begin
                  if (RETRY_EN && !retry_q) begin
                     retry_q     <= 1'b1;
                     state_q     <= ST_PULSE;
                     pulse_cnt_q <= '0;
                     coin_seen_q <= 1'b0;
                     drop1_q     <= (den_q == DEN_1);
                     drop2_q     <= (den_q == DEN_2);
                     drop5_q     <= (den_q == DEN_5);
                  end else begin
                     state_q <= ST_FAULT;
                     fault_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q + TW'(1);
               end
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               drop1_q <= 1'b0;
               drop2_q <= 1'b0;
               drop5_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.drop1 = drop1_q;
   assign bus.drop2 = drop2_q;
   assign bus.drop5 = drop5_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.fault = fault_q;
   assign bus.rem1  = rem1_q;
   assign bus.rem2  = rem2_q;
   assign bus.rem5  = rem5_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser: reset, payout order, zero load, late sense, timeout, aborts.
// Expectations follow DISPENSE_RETRY_EN when the bench is built with it.
module tb_coin_change_dispenser;
   localparam int CW          = 4;
   localparam int PULSE_LEN   = 4;
   localparam int ACK_TIMEOUT = 16;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   coin_change_dispenser_if #(.CW(CW)) bus ();

   coin_change_dispenser #(
      .CW          (CW),
      .PULSE_LEN   (PULSE_LEN),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_load(input logic [CW-1:0] c1, input logic [CW-1:0] c2, input logic [CW-1:0] c5);
      bus.load = 1'b1;
      bus.cnt1 = c1;
      bus.cnt2 = c2;
      bus.cnt5 = c5;
      tick();
      bus.load = 1'b0;
      bus.cnt1 = '0;
      bus.cnt2 = '0;
      bus.cnt5 = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.state !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected 0", bus.state);
      end
      n_checks++;
      if ({bus.drop1, bus.drop2, bus.drop5, bus.busy, bus.done, bus.fault} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {bus.drop1, bus.drop2, bus.drop5, bus.busy, bus.done, bus.fault});
      end
      n_checks++;
      if ({bus.rem1, bus.rem2, bus.rem5} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_rem: got %h expected 000", {bus.rem1, bus.rem2, bus.rem5});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_two_coins();
      int hi;
      drive_load(4'd0, 4'd1, 4'd1);
      n_checks++;
      if (bus.state !== 3'd1 || bus.busy !== 1'b1 || bus.rem5 !== 4'd1 || bus.rem2 !== 4'd1) begin
         n_fail++;
         $display("FAIL load_sel: got state=%0d busy=%b rem5=%0d rem2=%0d expected 1 1 1 1",
                  bus.state, bus.busy, bus.rem5, bus.rem2);
      end
      tick();
      hi = 0;
      for (int c = 0; c < PULSE_LEN; c++) begin
         if (bus.drop5 && !bus.drop2 && !bus.drop1) hi++;
         bus.sense = (c == 2);
         tick();
      end
      bus.sense = 1'b0;
      n_checks++;
      if (hi !== PULSE_LEN) begin
         n_fail++;
         $display("FAIL drop5_len: got %0d expected %0d", hi, PULSE_LEN);
      end
      n_checks++;
      if (bus.state !== 3'd1 || bus.drop5 !== 1'b0 || bus.drop2 !== 1'b0 || bus.rem5 !== 4'd0) begin
         n_fail++;
         $display("FAIL after_drop5: got state=%0d drop5=%b drop2=%b rem5=%0d expected 1 0 0 0",
                  bus.state, bus.drop5, bus.drop2, bus.rem5);
      end
      tick();
      hi = 0;
      for (int c = 0; c < PULSE_LEN; c++) begin
         if (bus.drop2 && !bus.drop5 && !bus.drop1) hi++;
         bus.sense = (c == 2);
         tick();
      end
      bus.sense = 1'b0;
      n_checks++;
      if (hi !== PULSE_LEN) begin
         n_fail++;
         $display("FAIL drop2_len: got %0d expected %0d", hi, PULSE_LEN);
      end
      n_checks++;
      if (bus.drop2 !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.state !== 3'd4 ||
          {bus.rem1, bus.rem2, bus.rem5} !== 12'h000) begin
         n_fail++;
         $display("FAIL payout_done: got drop2=%b done=%b busy=%b state=%0d rem=%h expected 0 1 0 4 000",
                  bus.drop2, bus.done, bus.busy, bus.state, {bus.rem1, bus.rem2, bus.rem5});
      end
      tick();
      n_checks++;
      if (bus.done !== 1'b0 || bus.state !== 3'd0) begin
         n_fail++;
         $display("FAIL done_one_cycle: got done=%b state=%0d expected 0 0", bus.done, bus.state);
      end
   endtask

   task automatic test_zero_load();
      drive_load(4'd0, 4'd0, 4'd0);
      n_checks++;
      if (bus.done !== 1'b1 || bus.state !== 3'd4 || bus.busy !== 1'b0 ||
          {bus.drop1, bus.drop2, bus.drop5} !== 3'b000) begin
         n_fail++;
         $display("FAIL zero_load: got done=%b state=%0d busy=%b drops=%b expected 1 4 0 000",
                  bus.done, bus.state, bus.busy, {bus.drop1, bus.drop2, bus.drop5});
      end
      tick();
      n_checks++;
      if (bus.done !== 1'b0 || bus.state !== 3'd0) begin
         n_fail++;
         $display("FAIL zero_load_idle: got done=%b state=%0d expected 0 0", bus.done, bus.state);
      end
   endtask

   task automatic test_late_sense();
      drive_load(4'd2, 4'd0, 4'd0);
      tick();
      for (int c = 0; c < PULSE_LEN; c++) tick();
      n_checks++;
      if (bus.state !== 3'd3 || bus.drop1 !== 1'b0 || bus.rem1 !== 4'd2) begin
         n_fail++;
         $display("FAIL enter_wait: got state=%0d drop1=%b rem1=%0d expected 3 0 2",
                  bus.state, bus.drop1, bus.rem1);
      end
      for (int c = 0; c < 5; c++) tick();
      bus.sense = 1'b1;
      tick();
      bus.sense = 1'b0;
      n_checks++;
      if (bus.state !== 3'd1 || bus.rem1 !== 4'd1) begin
         n_fail++;
         $display("FAIL late_sense_credit: got state=%0d rem1=%0d expected 1 1", bus.state, bus.rem1);
      end
      tick();
      n_checks++;
      if (bus.drop1 !== 1'b1 || bus.state !== 3'd2) begin
         n_fail++;
         $display("FAIL second_pulse: got drop1=%b state=%0d expected 1 2", bus.drop1, bus.state);
      end
      bus.sense = 1'b1;
      for (int c = 0; c < PULSE_LEN; c++) tick();
      bus.sense = 1'b0;
      n_checks++;
      if (bus.done !== 1'b1 || bus.rem1 !== 4'd0) begin
         n_fail++;
         $display("FAIL late_sense_done: got done=%b rem1=%0d expected 1 0", bus.done, bus.rem1);
      end
      tick();
   endtask

   task automatic test_one_credit_per_pulse();
      drive_load(4'd2, 4'd0, 4'd0);
      tick();
      bus.sense = 1'b1;
      for (int c = 0; c < PULSE_LEN; c++) tick();
      bus.sense = 1'b0;
      n_checks++;
      if (bus.rem1 !== 4'd1 || bus.state !== 3'd1) begin
         n_fail++;
         $display("FAIL one_credit: got rem1=%0d state=%0d expected 1 1", bus.rem1, bus.state);
      end
      tick();
      bus.sense = 1'b1;
      tick();
      bus.sense = 1'b0;
      for (int c = 1; c < PULSE_LEN; c++) tick();
      n_checks++;
      if (bus.done !== 1'b1 || bus.rem1 !== 4'd0) begin
         n_fail++;
         $display("FAIL one_credit_done: got done=%b rem1=%0d expected 1 0", bus.done, bus.rem1);
      end
      tick();
   endtask

   task automatic test_timeout();
      drive_load(4'd0, 4'd1, 4'd0);
      tick();
      for (int c = 0; c < PULSE_LEN; c++) tick();
`ifdef DISPENSE_RETRY_EN
      for (int c = 0; c < ACK_TIMEOUT; c++) tick();
      n_checks++;
      if (bus.drop2 !== 1'b1 || bus.state !== 3'd2 || bus.fault !== 1'b0) begin
         n_fail++;
         $display("FAIL retry_pulse: got drop2=%b state=%0d fault=%b expected 1 2 0",
                  bus.drop2, bus.state, bus.fault);
      end
      for (int c = 0; c < PULSE_LEN; c++) tick();
`endif
      for (int c = 0; c < ACK_TIMEOUT - 1; c++) tick();
      n_checks++;
      if (bus.fault !== 1'b0 || bus.state !== 3'd3) begin
         n_fail++;
         $display("FAIL pre_timeout: got fault=%b state=%0d expected 0 3", bus.fault, bus.state);
      end
      tick();
      n_checks++;
      if (bus.fault !== 1'b1 || bus.state !== 3'd5 || bus.rem2 !== 4'd1 || bus.busy !== 1'b0 ||
          {bus.drop1, bus.drop2, bus.drop5} !== 3'b000) begin
         n_fail++;
         $display("FAIL timeout_fault: got fault=%b state=%0d rem2=%0d busy=%b drops=%b expected 1 5 1 0 000",
                  bus.fault, bus.state, bus.rem2, bus.busy, {bus.drop1, bus.drop2, bus.drop5});
      end
      tick();
      n_checks++;
      if (bus.fault !== 1'b1 || bus.rem2 !== 4'd1) begin
         n_fail++;
         $display("FAIL fault_hold: got fault=%b rem2=%0d expected 1 1", bus.fault, bus.rem2);
      end
      drive_load(4'd0, 4'd0, 4'd0);
      n_checks++;
      if (bus.fault !== 1'b0 || bus.done !== 1'b1 || bus.rem2 !== 4'd0) begin
         n_fail++;
         $display("FAIL fault_reload: got fault=%b done=%b rem2=%0d expected 0 1 0",
                  bus.fault, bus.done, bus.rem2);
      end
      tick();
   endtask

   task automatic test_mid_ops();
      drive_load(4'd0, 4'd0, 4'd3);
      tick();
      drive_load(4'd7, 4'd7, 4'd7);
      n_checks++;
      if (bus.rem5 !== 4'd3 || bus.rem1 !== 4'd0 || bus.state !== 3'd2 || bus.drop5 !== 1'b1) begin
         n_fail++;
         $display("FAIL load_while_busy: got rem5=%0d rem1=%0d state=%0d drop5=%b expected 3 0 2 1",
                  bus.rem5, bus.rem1, bus.state, bus.drop5);
      end
      bus.sense = 1'b1;
      tick();
      bus.sense = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.rem5 !== 4'd2 || bus.state !== 3'd1) begin
         n_fail++;
         $display("FAIL mid_first_coin: got rem5=%0d state=%0d expected 2 1", bus.rem5, bus.state);
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.drop5 !== 1'b0 || bus.rem5 !== 4'd0 || bus.state !== 3'd0 || bus.done !== 1'b0 ||
          bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_reset: got drop5=%b rem5=%0d state=%0d done=%b busy=%b expected 0 0 0 0 0",
                  bus.drop5, bus.rem5, bus.state, bus.done, bus.busy);
      end
      bus.sense = 1'b1;
      tick();
      tick();
      bus.sense = 1'b0;
      tick();
      n_checks++;
      if (bus.state !== 3'd0 || bus.done !== 1'b0 || {bus.rem1, bus.rem2, bus.rem5} !== 12'h000 ||
          {bus.drop1, bus.drop2, bus.drop5} !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_sense: got state=%0d done=%b rem=%h drops=%b expected 0 0 000 000",
                  bus.state, bus.done, {bus.rem1, bus.rem2, bus.rem5}, {bus.drop1, bus.drop2, bus.drop5});
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.load  = 1'b0;
      bus.cnt1  = '0;
      bus.cnt2  = '0;
      bus.cnt5  = '0;
      bus.sense = 1'b0;
      test_reset();
      test_two_coins();
      test_zero_load();
      test_late_sense();
      test_one_credit_per_pulse();
      test_timeout();
      test_mid_ops();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
